tea_lane_scheduler: RTL and testbench

//  Single-clock, parametrised N-lane TEA engine farm with valid/ready streaming on both sides.

---
 rtl/tea_pkg.sv | 42 ++++
 rtl/tea_iter_lane.sv | 80 ++++++++
 rtl/tea_lane_scheduler.sv | 92 +++++++++
 tb/tb_tea_lane_scheduler.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tea_pkg.sv
`default_nettype none
// tea_pkg: TEA constants, block/key types, lane state encoding and single-round step functions.
// Revision: 1.0
package tea_pkg;

  localparam logic [31:0] TEA_DELTA = 32'h9E3779B9;

  typedef logic [63:0]  tea_block_t;
  typedef logic [127:0] tea_key_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } lane_state_t;

  function automatic logic [31:0] tea_mix(input logic [31:0] v, input logic [31:0] ka,
                                          input logic [31:0] kb, input logic [31:0] sum);
    return ((v << 4) + ka) ^ (v + sum) ^ ((v >> 5) + kb);
  endfunction

  // sum is the value already advanced by DELTA for this round
  function automatic tea_block_t tea_enc_step(input tea_block_t v, input tea_key_t k,
                                              input logic [31:0] sum);
    logic [31:0] v0;
    logic [31:0] v1;
    v0 = v[63:32] + tea_mix(v[31:0], k[127:96], k[95:64], sum);
    v1 = v[31:0]  + tea_mix(v0, k[63:32], k[31:0], sum);
    return {v0, v1};
  endfunction

  function automatic tea_block_t tea_dec_step(input tea_block_t v, input tea_key_t k,
                                              input logic [31:0] sum);
    logic [31:0] v0;
    logic [31:0] v1;
    v1 = v[31:0]  - tea_mix(v[63:32], k[63:32], k[31:0], sum);
    v0 = v[63:32] - tea_mix(v1, k[127:96], k[95:64], sum);
    return {v0, v1};
  endfunction

endpackage
`default_nettype wire

// File: rtl/tea_iter_lane.sv
`default_nettype none
// tea_iter_lane: one iterative TEA lane, one round per clock, holding its result until released.
// Revision: 1.0
module tea_iter_lane
  import tea_pkg::*;
#(
  parameter int          ROUNDS = 32,
  parameter logic [31:0] DELTA  = TEA_DELTA
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          load,
  input  logic          release_lane,
  input  logic [63:0]   in_block,
  input  logic [127:0]  in_key,
  input  logic          in_mode,
  output logic          idle,
  output logic          done,
  output logic [63:0]   result
);

  localparam int               CNT_W    = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
  localparam logic [63:0]      SUM_PROD = 64'(DELTA) * 64'(ROUNDS);
  localparam logic [31:0]      SUM_DEC  = SUM_PROD[31:0];
  localparam logic [CNT_W-1:0] LAST_RND = CNT_W'(ROUNDS - 1);

  lane_state_t      state;
  logic [CNT_W-1:0] rnd;
  tea_block_t       v;
  tea_key_t         key;
  logic             mode;
  logic [31:0]      sum;
  logic [31:0]      sum_enc;

  assign sum_enc = sum + DELTA;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      rnd   <= '0;
      v     <= '0;
      key   <= '0;
      mode  <= 1'b0;
      sum   <= '0;
    end else if (flush) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: if (load) begin
          state <= BUSY;
          v     <= in_block;
          key   <= in_key;
          mode  <= in_mode;
          sum   <= in_mode ? 32'd0 : SUM_DEC;
          rnd   <= '0;
        end
        BUSY: begin
          if (mode) begin
            v   <= tea_enc_step(v, key, sum_enc);
            sum <= sum_enc;
          end else begin
            v   <= tea_dec_step(v, key, sum);
            sum <= sum - DELTA;
          end
          rnd <= rnd + 1'b1;
          if (rnd == LAST_RND) state <= DONE;
        end
        DONE: if (release_lane) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign idle   = (state == IDLE);
  assign done   = (state == DONE);
  assign result = v;

endmodule
`default_nettype wire

// File: rtl/tea_lane_scheduler.sv
`default_nettype none
// tea_lane_scheduler: round-robin dispatch of TEA blocks to N iterative lanes, in-order collection.
// Revision: 1.0
module tea_lane_scheduler
  import tea_pkg::*;
#(
  parameter int          N_LANES = 8,
  parameter int          ROUNDS  = 32,
  parameter logic [31:0] DELTA   = TEA_DELTA
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [63:0]                  in_block,
  input  logic [127:0]                 in_key,
  input  logic                         in_mode,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [63:0]                  out_block,
  output logic [$clog2(N_LANES+1)-1:0] busy_cnt
);

  localparam int               PTR_W    = (N_LANES > 1) ? $clog2(N_LANES) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N_LANES - 1);

  logic [N_LANES-1:0] lane_idle;
  logic [N_LANES-1:0] lane_done;
  logic [N_LANES-1:0] lane_load;
  logic [N_LANES-1:0] lane_rel;
  logic [63:0]        lane_result [N_LANES];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               accept;
  logic               rel;

  // AND-OR select keeps out_block at zero unless the head lane is DONE
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_block = '0;
    for (int i = 0; i < N_LANES; i++) begin
      if (wr_ptr == PTR_W'(i)) in_ready = in_ready | lane_idle[i];
      if (rd_ptr == PTR_W'(i)) begin
        out_valid = out_valid | lane_done[i];
        out_block = out_block | (lane_result[i] & {64{lane_done[i]}});
      end
    end
  end

  assign accept = in_valid && in_ready;
  assign rel    = out_valid && out_ready;

  for (genvar g = 0; g < N_LANES; g++) begin : g_lanes
    assign lane_load[g] = accept && (wr_ptr == PTR_W'(g));
    assign lane_rel[g]  = rel && (rd_ptr == PTR_W'(g));

    tea_iter_lane #(.ROUNDS(ROUNDS), .DELTA(DELTA)) u_lane (
      .clk          (clk),
      .rst          (rst),
      .flush        (flush),
      .load         (lane_load[g]),
      .release_lane (lane_rel[g]),
      .in_block     (in_block),
      .in_key       (in_key),
      .in_mode      (in_mode),
      .idle         (lane_idle[g]),
      .done         (lane_done[g]),
      .result       (lane_result[g])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      busy_cnt <= '0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      busy_cnt <= '0;
    end else begin
      if (accept) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
      if (rel)    rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
      if (accept && !rel)      busy_cnt <= busy_cnt + 1'b1;
      else if (rel && !accept) busy_cnt <= busy_cnt - 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tea_lane_scheduler.sv
`default_nettype none
// tb_tea_lane_scheduler: directed self-checking bench, 8-lane and 5-lane instances, ROUNDS=32.
// Revision: 1.0
module tb_tea_lane_scheduler;

  localparam int ROUNDS = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, flush;
  logic         in_valid, in_valid5, out_ready, out_ready5;
  logic [63:0]  in_block;
  logic [127:0] in_key;
  logic         in_mode;
  logic         in_ready, out_valid, in_ready5, out_valid5;
  logic [63:0]  out_block, out_block5;
  logic [3:0]   busy_cnt;
  logic [2:0]   busy_cnt5;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [63:0]  q_blk[$];
  logic [63:0]  q_exp[$];
  logic [127:0] q_key[$];
  bit           q_mode[$];
  int           acc_cyc[$];

  tea_lane_scheduler #(.N_LANES(8), .ROUNDS(ROUNDS), .DELTA(32'h9E3779B9)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_block(in_block), .in_key(in_key), .in_mode(in_mode), .out_valid(out_valid),
    .out_ready(out_ready), .out_block(out_block), .busy_cnt(busy_cnt)
  );

  tea_lane_scheduler #(.N_LANES(5), .ROUNDS(ROUNDS), .DELTA(32'h9E3779B9)) dut5 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid5), .in_ready(in_ready5),
    .in_block(in_block), .in_key(in_key), .in_mode(in_mode), .out_valid(out_valid5),
    .out_ready(out_ready5), .out_block(out_block5), .busy_cnt(busy_cnt5)
  );

  // Whole-block TEA reference, written in the classic C form
  function automatic logic [63:0] ref_tea(input logic [63:0] b, input logic [127:0] k, input bit enc);
    logic [31:0] y, z, s;
    y = b[63:32];
    z = b[31:0];
    s = enc ? 32'd0 : 32'hC6EF3720;
    for (int r = 0; r < ROUNDS; r++) begin
      if (enc) begin
        s = s + 32'h9E3779B9;
        y = y + (((z << 4) + k[127:96]) ^ (z + s) ^ ((z >> 5) + k[95:64]));
        z = z + (((y << 4) + k[63:32]) ^ (y + s) ^ ((y >> 5) + k[31:0]));
      end else begin
        z = z - (((y << 4) + k[63:32]) ^ (y + s) ^ ((y >> 5) + k[31:0]));
        y = y - (((z << 4) + k[127:96]) ^ (z + s) ^ ((z >> 5) + k[95:64]));
        s = s - 32'h9E3779B9;
      end
    end
    return {y, z};
  endfunction

  task automatic push(input logic [63:0] b, input logic [127:0] k, input bit m, input logic [63:0] e);
    q_blk.push_back(b);
    q_key.push_back(k);
    q_mode.push_back(m);
    q_exp.push_back(e);
  endtask

  // Entered at a negedge; presents queued blocks and records the cycle each was accepted
  task automatic drive(input bit sel);
    int guard;
    while (q_blk.size() > 0) begin
      in_block = q_blk.pop_front();
      in_key   = q_key.pop_front();
      in_mode  = q_mode.pop_front();
      if (sel) in_valid5 = 1'b1; else in_valid = 1'b1;
      guard = 0;
      while (!(sel ? in_ready5 : in_ready) && guard < 2000) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 2000) begin
        vectors++; miscompares++;
        $display("FAIL drive_timeout in_ready stuck at 0, expected 1");
        q_blk.delete(); q_key.delete(); q_mode.delete();
      end else begin
        @(negedge clk);
        acc_cyc.push_back(cyc);
      end
    end
    in_valid = 1'b0;
    in_valid5 = 1'b0;
  endtask

  task automatic collect(input bit sel, input int n);
    int got, guard;
    logic [63:0] e, a;
    got = 0;
    guard = 0;
    while (got < n && guard < 4000) begin
      @(negedge clk);
      guard++;
      if (sel ? (out_valid5 && out_ready5) : (out_valid && out_ready)) begin
        e = q_exp.pop_front();
        a = sel ? out_block5 : out_block;
        vectors++;
        if (a !== e) begin
          miscompares++;
          $display("FAIL collect%0d[%0d] got %h expected %h", sel ? 5 : 8, got, a, e);
        end
        got++;
      end
    end
    if (got < n) begin
      vectors++; miscompares++;
      $display("FAIL collect_timeout got %0d outputs expected %0d", got, n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_valid5 = 1'b0;
    out_ready = 1'b0; out_ready5 = 1'b0; in_block = '0; in_key = '0; in_mode = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({in_ready, out_valid, out_block, busy_cnt} !== {1'b1, 1'b0, 64'd0, 4'd0}) begin
      miscompares++;
      $display("FAIL reset8 rdy=%b vld=%b blk=%h cnt=%0d expected 1 0 0 0", in_ready, out_valid, out_block, busy_cnt);
    end
    vectors++;
    if ({in_ready5, out_valid5, out_block5, busy_cnt5} !== {1'b1, 1'b0, 64'd0, 3'd0}) begin
      miscompares++;
      $display("FAIL reset5 rdy=%b vld=%b blk=%h cnt=%0d expected 1 0 0 0", in_ready5, out_valid5, out_block5, busy_cnt5);
    end
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (in_ready !== 1'b1 || busy_cnt !== 4'd0) begin
      miscompares++;
      $display("FAIL post_reset rdy=%b cnt=%0d expected 1 0", in_ready, busy_cnt);
    end
  endtask

  // Known vector encrypt then decrypt of it, with exact latency checks
  task automatic test_single_block();
    logic [63:0] blk[2];
    logic [63:0] exp[2];
    blk[0] = 64'd0;                  exp[0] = 64'h41EA3A0A_94BAA940;
    blk[1] = 64'h41EA3A0A_94BAA940;  exp[1] = 64'd0;
    for (int t = 0; t < 2; t++) begin
      @(negedge clk);
      out_ready = 1'b1; in_block = blk[t]; in_key = '0; in_mode = (t == 0); in_valid = 1'b1;
      vectors++;
      if (in_ready !== 1'b1) begin miscompares++; $display("FAIL single%0d_ready got %b expected 1", t, in_ready); end
      @(negedge clk);
      in_valid = 1'b0;
      vectors++;
      if (busy_cnt !== 4'd1 || out_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL single%0d_accept cnt=%0d vld=%b expected 1 0", t, busy_cnt, out_valid);
      end
      repeat (31) @(negedge clk);
      vectors++;
      if (out_valid !== 1'b0) begin miscompares++; $display("FAIL single%0d_early out_valid=%b expected 0 after 31 rounds", t, out_valid); end
      @(negedge clk);
      vectors++;
      if (out_valid !== 1'b1 || out_block !== exp[t]) begin
        miscompares++;
        $display("FAIL single%0d_result vld=%b blk=%h expected 1 %h", t, out_valid, out_block, exp[t]);
      end
      @(negedge clk);
      vectors++;
      if (out_valid !== 1'b0 || out_block !== 64'd0 || busy_cnt !== 4'd0) begin
        miscompares++;
        $display("FAIL single%0d_release vld=%b blk=%h cnt=%0d expected 0 0 0", t, out_valid, out_block, busy_cnt);
      end
    end
  endtask

  task automatic test_round_trip();
    logic [63:0]  pt[64];
    logic [63:0]  ct[64];
    logic [127:0] ky[64];
    @(negedge clk);
    out_ready = 1'b1;
    for (int i = 0; i < 64; i++) begin
      pt[i] = {$urandom, $urandom};
      ky[i] = {$urandom, $urandom, $urandom, $urandom};
      ct[i] = ref_tea(pt[i], ky[i], 1'b1);
      push(pt[i], ky[i], 1'b1, ct[i]);
    end
    fork drive(1'b0); collect(1'b0, 64); join
    for (int i = 0; i < 64; i++) push(ct[i], ky[i], 1'b0, pt[i]);
    fork drive(1'b0); collect(1'b0, 64); join
  endtask

  task automatic test_back_to_back();
    logic [63:0]  b;
    logic [127:0] k;
    @(negedge clk);
    out_ready = 1'b1;
    acc_cyc.delete();
    for (int i = 0; i < 16; i++) begin
      b = {$urandom, $urandom};
      k = {$urandom, $urandom, $urandom, $urandom};
      push(b, k, 1'b1, ref_tea(b, k, 1'b1));
    end
    fork drive(1'b0); collect(1'b0, 16); join
    for (int i = 1; i < 8; i++) begin
      vectors++;
      if (acc_cyc[i] - acc_cyc[0] !== i) begin
        miscompares++;
        $display("FAIL b2b_accept%0d offset %0d expected %0d", i, acc_cyc[i] - acc_cyc[0], i);
      end
    end
    // lane 0 releases at E33 and may be reloaded at E34
    vectors++;
    if (acc_cyc[8] - acc_cyc[0] !== 34) begin
      miscompares++;
      $display("FAIL b2b_refill offset %0d expected 34", acc_cyc[8] - acc_cyc[0]);
    end
    vectors++;
    if (acc_cyc[15] - acc_cyc[8] !== 7) begin
      miscompares++;
      $display("FAIL b2b_second_wave span %0d expected 7", acc_cyc[15] - acc_cyc[8]);
    end
  endtask

  task automatic test_stall();
    logic [63:0]  b;
    logic [127:0] k;
    int bad;
    @(negedge clk);
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      b = {$urandom, $urandom};
      k = {$urandom, $urandom, $urandom, $urandom};
      push(b, k, i[0], ref_tea(b, k, i[0]));
    end
    drive(1'b0);
    repeat (40) @(negedge clk);
    bad = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (out_block !== q_exp[0] || out_valid !== 1'b1) bad++;
    end
    vectors++;
    if (busy_cnt !== 4'd8 || in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_full cnt=%0d rdy=%b expected 8 0", busy_cnt, in_ready);
    end
    vectors++;
    if (bad !== 0) begin
      miscompares++;
      $display("FAIL stall_hold %0d unstable cycles, last blk=%h expected %h", bad, out_block, q_exp[0]);
    end
    out_ready = 1'b1;
    for (int j = 0; j < 8; j++) begin
      vectors++;
      if (out_valid !== 1'b1 || out_block !== q_exp[0]) begin
        miscompares++;
        $display("FAIL drain[%0d] vld=%b blk=%h expected 1 %h", j, out_valid, out_block, q_exp[0]);
      end
      void'(q_exp.pop_front());
      @(negedge clk);
    end
    vectors++;
    if (out_valid !== 1'b0 || busy_cnt !== 4'd0) begin
      miscompares++;
      $display("FAIL drain_empty vld=%b cnt=%0d expected 0 0", out_valid, busy_cnt);
    end
  endtask

  task automatic test_wrap5();
    logic [63:0]  b;
    logic [127:0] k;
    @(negedge clk);
    out_ready5 = 1'b1;
    for (int i = 0; i < 12; i++) begin
      b = {$urandom, $urandom};
      k = {$urandom, $urandom, $urandom, $urandom};
      push(b, k, i[1], ref_tea(b, k, i[1]));
    end
    fork drive(1'b1); collect(1'b1, 12); join
    @(negedge clk);
    vectors++;
    if (busy_cnt5 !== 3'd0 || in_ready5 !== 1'b1) begin
      miscompares++;
      $display("FAIL wrap5_end cnt=%0d rdy=%b expected 0 1", busy_cnt5, in_ready5);
    end
  endtask

  task automatic test_flush();
    logic [63:0]  b;
    logic [127:0] k;
    for (int pass = 0; pass < 2; pass++) begin
      @(negedge clk);
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
        b = {$urandom, $urandom};
        push(b, '0, 1'b1, 64'd0);
      end
      drive(1'b0);
      repeat (5) @(negedge clk);
      vectors++;
      if (busy_cnt !== 4'd3) begin miscompares++; $display("FAIL abort%0d_pre cnt=%0d expected 3", pass, busy_cnt); end
      q_exp.delete();
      if (pass == 0) begin
        flush = 1'b1; in_valid = 1'b1; in_block = 64'hDEAD_BEEF_0123_4567; in_key = '1; in_mode = 1'b1;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
      end else begin
        #2 rst = 1'b1;
        #1;
        vectors++;
        if (busy_cnt !== 4'd0) begin miscompares++; $display("FAIL rst_async cnt=%0d expected 0", busy_cnt); end
        @(negedge clk);
        rst = 1'b0;
      end
      vectors++;
      if (busy_cnt !== 4'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL abort%0d_state cnt=%0d vld=%b rdy=%b expected 0 0 1", pass, busy_cnt, out_valid, in_ready);
      end
      b = {$urandom, $urandom};
      k = {$urandom, $urandom, $urandom, $urandom};
      push(b, k, 1'b0, ref_tea(b, k, 1'b0));
      fork drive(1'b0); collect(1'b0, 1); join
      @(negedge clk);
      vectors++;
      if (busy_cnt !== 4'd0 || out_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL abort%0d_after cnt=%0d vld=%b expected 0 0", pass, busy_cnt, out_valid);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_block();
    test_round_trip();
    test_back_to_back();
    test_stall();
    test_wrap5();
    test_flush();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
